// File: rtl/fft_buffer_pkg.sv
// Shared types and constants for the FFT sample buffer.
package fft_buffer_pkg;

    localparam int unsigned BUF_SAMPLE_WIDTH = 16;
    localparam int unsigned BUF_ADDR_WIDTH   = 12;
    localparam int unsigned BUF_DEPTH        = 1 << BUF_ADDR_WIDTH;

    // Bridge samples are real-only; the imaginary half is stored as zero.
    localparam logic [BUF_SAMPLE_WIDTH-1:0] IMAG_ZERO = '0;

    // Frame ownership: bridge loads, engine computes, bridge reads results.
    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_CALC,
        S_RESULT
    } buf_state_t;

endpackage

// File: rtl/fft_buffer_mem.sv
// One-write / two-read frame storage: port A asynchronous read, port B registered read.
module fft_buffer_mem
    import fft_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = BUF_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    output logic [DATA_WIDTH-1:0] o_a_data,
    input  logic                  i_b_en,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    output logic [DATA_WIDTH-1:0] o_b_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Single write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Port A: combinational read for the bridge.
    always_comb begin
        o_a_data = mem[i_a_addr];
    end

    // Port B: registered read that holds when idle; same-cycle write returns old data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_b_data <= '0;
        end else if (i_b_en) begin
            o_b_data <= mem[i_b_addr];
        end
    end

endmodule

// File: rtl/fft_sample_buffer.sv
// Frame buffer between the AXI bridge RAM port and the FFT engine, with ownership handover.
module fft_sample_buffer
    import fft_buffer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_WRITE_ram,
    input  logic                  i_READ_ram,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE_ram,
    input  logic [ADDR_WIDTH-1:0] i_SAMPLE_INDEX_ram,
    input  logic                  i_DATA_LOADED,
    output logic [DATA_WIDTH-1:0] o_DATA_FROM_RAM,
    output logic                  o_CALC_END,
    output logic                  o_START,
    output logic [ADDR_WIDTH:0]   o_N_SAMPLES,
    input  logic                  i_ENG_DONE,
    input  logic                  i_ENG_RD,
    input  logic                  i_ENG_WR,
    input  logic [ADDR_WIDTH-1:0] i_ENG_ADDR,
    input  logic [DATA_WIDTH-1:0] i_ENG_WDATA,
    output logic [DATA_WIDTH-1:0] o_ENG_RDATA,
    output logic                  o_ACCESS_ERR
);

    localparam logic [ADDR_WIDTH:0] N_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    buf_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] max_idx;
    logic                  have_data;
    logic [ADDR_WIDTH-1:0] load_max;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_a_data;
    logic                  eng_rd_en;
    logic                  bridge_rd_ok;
    logic                  err_evt;

    fft_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (1 << ADDR_WIDTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (mem_we),
        .i_wr_addr (mem_waddr),
        .i_wr_data (mem_wdata),
        .i_a_addr  (i_SAMPLE_INDEX_ram),
        .o_a_data  (rd_a_data),
        .i_b_en    (eng_rd_en),
        .i_b_addr  (i_ENG_ADDR),
        .o_b_data  (o_ENG_RDATA)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, write-port mux by owner, strobes and access-error detection.
    always_comb begin
        state_nxt       = state;
        mem_we          = 1'b0;
        mem_waddr       = i_SAMPLE_INDEX_ram;
        mem_wdata       = {i_SAMPLE_ram, SAMPLE_WIDTH'(IMAG_ZERO)};
        eng_rd_en       = 1'b0;
        bridge_rd_ok    = 1'b0;
        err_evt         = 1'b0;
        o_START         = 1'b0;
        o_CALC_END      = 1'b0;
        o_DATA_FROM_RAM = '0;
        case (state)
            S_LOAD: begin
                mem_we  = i_WRITE_ram;
                err_evt = i_READ_ram | i_ENG_RD | i_ENG_WR;
                if (i_DATA_LOADED) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                o_START   = 1'b1;
                err_evt   = i_WRITE_ram | i_READ_ram | i_ENG_RD | i_ENG_WR;
                state_nxt = S_CALC;
            end
            S_CALC: begin
                mem_we    = i_ENG_WR;
                mem_waddr = i_ENG_ADDR;
                mem_wdata = i_ENG_WDATA;
                eng_rd_en = i_ENG_RD;
                err_evt   = i_WRITE_ram | i_READ_ram;
                if (i_ENG_DONE) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                o_CALC_END = 1'b1;
                err_evt    = i_ENG_RD | i_ENG_WR;
                if (i_WRITE_ram) begin
                    mem_we    = 1'b1;
                    state_nxt = S_LOAD;
                end else begin
                    bridge_rd_ok = i_READ_ram;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
        if (bridge_rd_ok) begin
            o_DATA_FROM_RAM = rd_a_data;
        end
    end

    // Highest index seen so far in this frame, including the current write.
    always_comb begin
        load_max = (have_data && (max_idx > i_SAMPLE_INDEX_ram)) ? max_idx : i_SAMPLE_INDEX_ram;
    end

    // Frame length tracking; the frame-opening write in S_RESULT seeds the next frame's max.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            max_idx     <= '0;
            have_data   <= 1'b0;
            o_N_SAMPLES <= '0;
        end else if (state == S_LOAD) begin
            if (i_DATA_LOADED) begin
                if (i_WRITE_ram) begin
                    o_N_SAMPLES <= {1'b0, load_max} + N_ONE;
                end else if (have_data) begin
                    o_N_SAMPLES <= {1'b0, max_idx} + N_ONE;
                end else begin
                    o_N_SAMPLES <= '0;
                end
                max_idx   <= '0;
                have_data <= 1'b0;
            end else if (i_WRITE_ram) begin
                max_idx   <= load_max;
                have_data <= 1'b1;
            end
        end else if ((state == S_RESULT) && i_WRITE_ram) begin
            max_idx   <= i_SAMPLE_INDEX_ram;
            have_data <= 1'b1;
        end
    end

    // Sticky access-error flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ACCESS_ERR <= 1'b0;
        end else if (err_evt) begin
            o_ACCESS_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Self-checking bench for fft_sample_buffer against a behavioural frame/memory model.
module tb_fft_sample_buffer;

    localparam int SW = 16;
    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_WRITE_ram, i_READ_ram, i_DATA_LOADED;
    logic [SW-1:0] i_SAMPLE_ram;
    logic [AW-1:0] i_SAMPLE_INDEX_ram;
    logic [DW-1:0] o_DATA_FROM_RAM;
    logic          o_CALC_END, o_START, o_ACCESS_ERR;
    logic [AW:0]   o_N_SAMPLES;
    logic          i_ENG_DONE, i_ENG_RD, i_ENG_WR;
    logic [AW-1:0] i_ENG_ADDR;
    logic [DW-1:0] i_ENG_WDATA;
    logic [DW-1:0] o_ENG_RDATA;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [4096];
    bit            ref_valid [4096];
    int            frame_idx [$];
    logic [DW-1:0] last_rd;

    fft_sample_buffer #(
        .SAMPLE_WIDTH (SW),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_WRITE_ram        (i_WRITE_ram),
        .i_READ_ram         (i_READ_ram),
        .i_SAMPLE_ram       (i_SAMPLE_ram),
        .i_SAMPLE_INDEX_ram (i_SAMPLE_INDEX_ram),
        .i_DATA_LOADED      (i_DATA_LOADED),
        .o_DATA_FROM_RAM    (o_DATA_FROM_RAM),
        .o_CALC_END         (o_CALC_END),
        .o_START            (o_START),
        .o_N_SAMPLES        (o_N_SAMPLES),
        .i_ENG_DONE         (i_ENG_DONE),
        .i_ENG_RD           (i_ENG_RD),
        .i_ENG_WR           (i_ENG_WR),
        .i_ENG_ADDR         (i_ENG_ADDR),
        .i_ENG_WDATA        (i_ENG_WDATA),
        .o_ENG_RDATA        (o_ENG_RDATA),
        .o_ACCESS_ERR       (o_ACCESS_ERR)
    );

    always #5 clk = ~clk;

    task automatic idle();
        i_WRITE_ram        = 1'b0;
        i_READ_ram         = 1'b0;
        i_SAMPLE_ram       = '0;
        i_SAMPLE_INDEX_ram = '0;
        i_DATA_LOADED      = 1'b0;
        i_ENG_DONE         = 1'b0;
        i_ENG_RD           = 1'b0;
        i_ENG_WR           = 1'b0;
        i_ENG_ADDR         = '0;
        i_ENG_WDATA        = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_idx.delete();
        last_rd = '0;
    endtask

    // Successful bridge write: model stores the sample with a zero imaginary half.
    task automatic bridge_write(input int idx, input logic [SW-1:0] v, input bit last);
        @(negedge clk);
        idle();
        i_WRITE_ram        = 1'b1;
        i_SAMPLE_INDEX_ram = AW'(idx);
        i_SAMPLE_ram       = v;
        i_DATA_LOADED      = last;
        ref_mem[idx]   = {v, 16'h0000};
        ref_valid[idx] = 1'b1;
        frame_idx.push_back(idx);
    endtask

    function automatic int exp_n();
        int m;
        if (frame_idx.size() == 0) return 0;
        m = 0;
        foreach (frame_idx[i]) if (frame_idx[i] > m) m = frame_idx[i];
        return m + 1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        checks++; if (o_CALC_END !== 1'b0) begin errors++; $display("FAIL reset_calc_end: got %b expected 0", o_CALC_END); end
        checks++; if (o_START !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", o_START); end
        checks++; if (o_N_SAMPLES !== '0) begin errors++; $display("FAIL reset_n_samples: got %0d expected 0", o_N_SAMPLES); end
        checks++; if (o_ENG_RDATA !== '0) begin errors++; $display("FAIL reset_eng_rdata: got %h expected 0", o_ENG_RDATA); end
        checks++; if (o_ACCESS_ERR !== 1'b0) begin errors++; $display("FAIL reset_access_err: got %b expected 0", o_ACCESS_ERR); end
        checks++; if (o_DATA_FROM_RAM !== '0) begin errors++; $display("FAIL reset_data_from_ram: got %h expected 0", o_DATA_FROM_RAM); end
        @(negedge clk);
        rst = 1'b0;
        frame_idx.delete();
        last_rd = '0;
    endtask

    task automatic test_load_basic();
        for (int i = 0; i < 8; i++) bridge_write(i, SW'(i + 1), i == 7);
        @(negedge clk);
        idle();
        checks++; if (o_START !== 1'b1) begin errors++; $display("FAIL load_start_pulse: got %b expected 1", o_START); end
        checks++; if (o_N_SAMPLES !== 13'd8) begin errors++; $display("FAIL load_n_samples: got %0d expected 8", o_N_SAMPLES); end
        @(negedge clk);
        checks++; if (o_START !== 1'b0) begin errors++; $display("FAIL load_start_width: got %b expected 0", o_START); end
        checks++; if (o_ACCESS_ERR !== 1'b0) begin errors++; $display("FAIL load_no_err: got %b expected 0", o_ACCESS_ERR); end
    endtask

    task automatic test_engine_directed();
        // read mem[3] loaded by the bridge
        i_ENG_RD = 1'b1; i_ENG_ADDR = 12'd3;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== 32'h0004_0000) begin errors++; $display("FAIL eng_read_mem3: got %h expected 00040000", o_ENG_RDATA); end
        i_ENG_WR = 1'b1; i_ENG_ADDR = 12'd5; i_ENG_WDATA = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== 32'h0004_0000) begin errors++; $display("FAIL eng_rdata_hold: got %h expected 00040000", o_ENG_RDATA); end
        i_ENG_RD = 1'b1; i_ENG_ADDR = 12'd5;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL eng_read_after_write: got %h expected deadbeef", o_ENG_RDATA); end
        // same-cycle read and write of one address returns the old word
        i_ENG_RD = 1'b1; i_ENG_WR = 1'b1; i_ENG_ADDR = 12'd6; i_ENG_WDATA = 32'h1234_5678;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== 32'h0007_0000) begin errors++; $display("FAIL eng_rw_same_addr_old: got %h expected 00070000", o_ENG_RDATA); end
        ref_mem[6] = 32'h1234_5678;
        i_ENG_RD = 1'b1; i_ENG_ADDR = 12'd6;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== 32'h1234_5678) begin errors++; $display("FAIL eng_rw_same_addr_new: got %h expected 12345678", o_ENG_RDATA); end
        last_rd = 32'h1234_5678;
    endtask

    task automatic test_calc_bridge_block();
        i_WRITE_ram = 1'b1; i_SAMPLE_INDEX_ram = 12'd2; i_SAMPLE_ram = 16'h5555;
        @(negedge clk);
        idle();
        checks++; if (o_ACCESS_ERR !== 1'b1) begin errors++; $display("FAIL calc_bridge_write_err: got %b expected 1", o_ACCESS_ERR); end
        i_ENG_RD = 1'b1; i_ENG_ADDR = 12'd2;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== 32'h0003_0000) begin errors++; $display("FAIL calc_bridge_write_dropped: got %h expected 00030000", o_ENG_RDATA); end
        checks++; if (o_ACCESS_ERR !== 1'b1) begin errors++; $display("FAIL calc_err_sticky: got %b expected 1", o_ACCESS_ERR); end
        last_rd = 32'h0003_0000;
    endtask

    task automatic test_engine_random();
        logic [DW-1:0] exp_rd;
        int a;
        bit do_rd, do_wr;
        exp_rd = last_rd;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            checks++; if (o_ENG_RDATA !== exp_rd) begin errors++; $display("FAIL eng_random[%0d]: got %h expected %h", n, o_ENG_RDATA, exp_rd); end
            idle();
            do_wr = $urandom_range(0, 1) == 1;
            do_rd = $urandom_range(0, 1) == 1;
            if (do_rd) begin
                a = $urandom_range(0, 15);
                if (ref_valid[a]) begin
                    i_ENG_RD = 1'b1; i_ENG_ADDR = AW'(a);
                    exp_rd = ref_mem[a];
                end
            end
            if (do_wr && !i_ENG_RD) begin
                a = $urandom_range(8, 15);
                i_ENG_WR = 1'b1; i_ENG_ADDR = AW'(a); i_ENG_WDATA = $urandom;
                ref_mem[a] = i_ENG_WDATA; ref_valid[a] = 1'b1;
            end
        end
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== exp_rd) begin errors++; $display("FAIL eng_random_last: got %h expected %h", o_ENG_RDATA, exp_rd); end
        last_rd = exp_rd;
    endtask

    task automatic test_result_readout();
        int a;
        i_ENG_DONE = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (o_CALC_END !== 1'b1) begin errors++; $display("FAIL result_calc_end: got %b expected 1", o_CALC_END); end
        i_READ_ram = 1'b1; i_SAMPLE_INDEX_ram = 12'd5;
        #1;
        checks++; if (o_DATA_FROM_RAM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL result_read_idx5: got %h expected deadbeef", o_DATA_FROM_RAM); end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            idle();
            a = $urandom_range(0, 15);
            if (!ref_valid[a]) a = 0;
            i_READ_ram = 1'b1; i_SAMPLE_INDEX_ram = AW'(a);
            #1;
            checks++; if (o_DATA_FROM_RAM !== ref_mem[a]) begin errors++; $display("FAIL result_read[%0d]: got %h expected %h", a, o_DATA_FROM_RAM, ref_mem[a]); end
        end
        @(negedge clk);
        idle();
        i_SAMPLE_INDEX_ram = 12'd5;
        #1;
        checks++; if (o_DATA_FROM_RAM !== '0) begin errors++; $display("FAIL result_no_read_zero: got %h expected 0", o_DATA_FROM_RAM); end
        checks++; if (o_CALC_END !== 1'b1) begin errors++; $display("FAIL result_calc_end_held: got %b expected 1", o_CALC_END); end
        // write and read together: write wins and opens a new frame
        frame_idx.delete();
        bridge_write(0, 16'h00AA, 1'b0);
        i_READ_ram = 1'b1;
        #1;
        checks++; if (o_DATA_FROM_RAM !== '0) begin errors++; $display("FAIL result_write_wins: got %h expected 0", o_DATA_FROM_RAM); end
        @(negedge clk);
        idle();
        checks++; if (o_CALC_END !== 1'b0) begin errors++; $display("FAIL result_calc_end_drop: got %b expected 0", o_CALC_END); end
    endtask

    task automatic test_random_frame();
        logic [DW-1:0] exp_rd;
        int k, a;
        k = $urandom_range(6, 12);
        for (int n = 0; n < k; n++) bridge_write($urandom_range(16, 200), SW'($urandom), 1'b0);
        @(negedge clk);
        idle();
        i_DATA_LOADED = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (o_START !== 1'b1) begin errors++; $display("FAIL frame_start: got %b expected 1", o_START); end
        checks++; if (o_N_SAMPLES !== 13'(exp_n())) begin errors++; $display("FAIL frame_n_samples: got %0d expected %0d", o_N_SAMPLES, exp_n()); end
        @(negedge clk);
        exp_rd = last_rd;
        foreach (frame_idx[i]) begin
            i_ENG_RD = 1'b1; i_ENG_ADDR = AW'(frame_idx[i]);
            exp_rd = ref_mem[frame_idx[i]];
            @(negedge clk);
            idle();
            checks++; if (o_ENG_RDATA !== exp_rd) begin errors++; $display("FAIL frame_eng_read[%0d]: got %h expected %h", frame_idx[i], o_ENG_RDATA, exp_rd); end
        end
        last_rd = exp_rd;
        i_ENG_DONE = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (o_CALC_END !== 1'b1) begin errors++; $display("FAIL frame_calc_end: got %b expected 1", o_CALC_END); end
        for (int n = 0; n < 6; n++) begin
            a = frame_idx[$urandom_range(0, frame_idx.size() - 1)];
            i_READ_ram = 1'b1; i_SAMPLE_INDEX_ram = AW'(a);
            #1;
            checks++; if (o_DATA_FROM_RAM !== ref_mem[a]) begin errors++; $display("FAIL frame_bridge_read[%0d]: got %h expected %h", a, o_DATA_FROM_RAM, ref_mem[a]); end
            @(negedge clk);
            idle();
        end
    endtask

    task automatic test_errors();
        apply_reset();
        @(negedge clk);
        i_ENG_DONE = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (o_CALC_END !== 1'b0) begin errors++; $display("FAIL err_done_in_load: got %b expected 0", o_CALC_END); end
        checks++; if (o_ACCESS_ERR !== 1'b0) begin errors++; $display("FAIL err_done_no_err: got %b expected 0", o_ACCESS_ERR); end
        i_READ_ram = 1'b1; i_SAMPLE_INDEX_ram = 12'd0;
        #1;
        checks++; if (o_DATA_FROM_RAM !== '0) begin errors++; $display("FAIL err_read_in_load: got %h expected 0", o_DATA_FROM_RAM); end
        @(negedge clk);
        idle();
        checks++; if (o_ACCESS_ERR !== 1'b1) begin errors++; $display("FAIL err_read_in_load_flag: got %b expected 1", o_ACCESS_ERR); end
        i_DATA_LOADED = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (o_N_SAMPLES !== '0) begin errors++; $display("FAIL err_empty_load_n: got %0d expected 0", o_N_SAMPLES); end
        // engine write in S_START must be ignored
        i_ENG_WR = 1'b1; i_ENG_ADDR = 12'd1; i_ENG_WDATA = 32'hFFFF_FFFF;
        @(negedge clk);
        idle();
        i_ENG_RD = 1'b1; i_ENG_ADDR = 12'd1;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== ref_mem[1]) begin errors++; $display("FAIL err_eng_write_in_start: got %h expected %h", o_ENG_RDATA, ref_mem[1]); end
    endtask

    task automatic test_boundary();
        logic [SW-1:0] v;
        apply_reset();
        v = SW'($urandom);
        bridge_write(4095, v, 1'b1);
        @(negedge clk);
        idle();
        checks++; if (o_N_SAMPLES !== 13'd4096) begin errors++; $display("FAIL bound_n_4096: got %0d expected 4096", o_N_SAMPLES); end
        @(negedge clk);
        i_ENG_RD = 1'b1; i_ENG_ADDR = 12'd4095;
        @(negedge clk);
        idle();
        checks++; if (o_ENG_RDATA !== {v, 16'h0000}) begin errors++; $display("FAIL bound_read_4095: got %h expected %h", o_ENG_RDATA, {v, 16'h0000}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (o_ENG_RDATA !== '0) begin errors++; $display("FAIL mid_reset_eng_rdata: got %h expected 0", o_ENG_RDATA); end
        checks++; if (o_N_SAMPLES !== '0) begin errors++; $display("FAIL mid_reset_n_samples: got %0d expected 0", o_N_SAMPLES); end
        @(negedge clk);
        rst = 1'b0;
        i_ENG_DONE = 1'b1;
        @(negedge clk);
        idle();
        checks++; if (o_CALC_END !== 1'b0) begin errors++; $display("FAIL mid_reset_no_calc_end: got %b expected 0", o_CALC_END); end
        checks++; if (o_START !== 1'b0) begin errors++; $display("FAIL mid_reset_no_start: got %b expected 0", o_START); end
        @(negedge clk);
        checks++; if (o_CALC_END !== 1'b0) begin errors++; $display("FAIL mid_reset_calc_end_later: got %b expected 0", o_CALC_END); end
        checks++; if (o_ACCESS_ERR !== 1'b0) begin errors++; $display("FAIL mid_reset_access_err: got %b expected 0", o_ACCESS_ERR); end
    endtask

    initial begin
        idle();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        last_rd = '0;
        test_reset();
        test_load_basic();
        test_engine_directed();
        test_calc_bridge_block();
        test_engine_random();
        test_result_readout();
        test_random_frame();
        test_errors();
        test_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
